// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller.
// Latency: none (constants, types and a pure combinational lookup).
// Backpressure: not applicable.
package seg_pkg;

    // Converter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Largest decimal width the converter ever needs: 2^27-1 has 9 digits.
    localparam int BCD_MAX_DIGITS = 9;

    // Glyphs, bit order g f e d c b a, active-high.
    localparam logic [6:0] FONT_0      = 7'h3F;
    localparam logic [6:0] FONT_1      = 7'h06;
    localparam logic [6:0] FONT_2      = 7'h5B;
    localparam logic [6:0] FONT_3      = 7'h4F;
    localparam logic [6:0] FONT_4      = 7'h66;
    localparam logic [6:0] FONT_5      = 7'h6D;
    localparam logic [6:0] FONT_6      = 7'h7D;
    localparam logic [6:0] FONT_7      = 7'h07;
    localparam logic [6:0] FONT_8      = 7'h7F;
    localparam logic [6:0] FONT_9      = 7'h6F;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    // Decimal nibble to segment pattern; anything above 9 renders dark.
    function automatic logic [6:0] font_lookup(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = FONT_0;
            4'd1:    pat = FONT_1;
            4'd2:    pat = FONT_2;
            4'd3:    pat = FONT_3;
            4'd4:    pat = FONT_4;
            4'd5:    pat = FONT_5;
            4'd6:    pat = FONT_6;
            4'd7:    pat = FONT_7;
            4'd8:    pat = FONT_8;
            4'd9:    pat = FONT_9;
            default: pat = GLYPH_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Latency: busy for VALUE_W+1 cycles after start; done pulses in the last busy cycle.
// Backpressure: start is only honoured in IDLE; starts while busy are dropped.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [VALUE_W-1:0]      i_value,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_overflow
);

    // Full-width BCD accumulator so any VALUE_W fits; the display only
    // takes the low NUM_DIGITS nibbles and anything above flags overflow.
    localparam int BCD_W = 4 * BCD_MAX_DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic [VALUE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic [BCD_W-1:0]   w_bcd_adj;

    // Add-3 correction on every nibble that would exceed 9 after doubling.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int d = 0; d < BCD_MAX_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: one shift per cycle for VALUE_W cycles, then one commit cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_W'(VALUE_W - 1)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, then shift the binary MSB into the BCD field.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_bin <= i_value;
                        r_bcd <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                    r_cnt          <= r_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_busy     = (r_state != ST_IDLE);
    assign o_done     = (r_state == ST_COMMIT);
    assign o_bcd      = r_bcd[4*NUM_DIGITS-1:0];
    assign o_overflow = |r_bcd[BCD_W-1:4*NUM_DIGITS];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller: converts a binary value to decimal and scans the digits.
// Latency: new value on the digits VALUE_W+1 cycles after accept; an/seg lag the scan index by one cycle.
// Backpressure: busy high during conversion; loads arriving while busy are dropped, not queued.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [VALUE_W-1:0]    i_value,
    input  logic                  i_load,
    output logic                  o_busy,
    input  logic                  i_blank_lz,
    input  logic [NUM_DIGITS-1:0] i_dp,
    output logic [7:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an,
    output logic                  o_overflow
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        r_refresh_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_overflow;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_conv_done;
    logic [4*NUM_DIGITS-1:0] w_conv_bcd;
    logic                    w_conv_ovf;

    logic [IDX_W-1:0]        w_idx_eff;
    logic [4*NUM_DIGITS-1:0] w_digits_eff;
    logic                    w_ovf_eff;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic                    w_seen_nonzero;
    logic [3:0]              w_nib;
    logic                    w_blank_sel;
    logic                    w_dp_sel;
    logic [6:0]              w_glyph;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_value    (i_value),
        .i_start    (i_load),
        .o_busy     (o_busy),
        .o_done     (w_conv_done),
        .o_bcd      (w_conv_bcd),
        .o_overflow (w_conv_ovf)
    );

    // Refresh divider and scan index; the index wraps at NUM_DIGITS-1, not at a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_refresh_cnt <= '0;
            r_idx         <= '0;
        end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
        end
    end

    // Displayed digits only change on the converter's commit cycle, never mid-conversion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digits   <= '0;
            r_overflow <= 1'b0;
        end else if (w_conv_done) begin
            r_digits   <= w_conv_bcd;
            r_overflow <= w_conv_ovf;
        end
    end

    // While reset is asserted the output stage renders the post-reset state, so the
    // output registers show digit 0 / glyph "0" straight out of reset.
    assign w_idx_eff    = i_rst ? '0 : r_idx;
    assign w_digits_eff = i_rst ? '0 : r_digits;
    assign w_ovf_eff    = i_rst ? 1'b0 : r_overflow;

    // Leading-zero map: a digit is dark if it and every digit above it are zero;
    // digit 0 always shows so a zero value still reads "0".
    always_comb begin
        w_seen_nonzero = 1'b0;
        w_blank        = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_seen_nonzero = w_seen_nonzero | (w_digits_eff[4*i +: 4] != 4'd0);
            w_blank[i]     = i_blank_lz & ~w_seen_nonzero & (i != 0);
        end
    end

    // Pick the scanned digit's nibble, blank flag and decimal point; build one-hot anode.
    always_comb begin
        w_nib       = 4'd0;
        w_blank_sel = 1'b0;
        w_dp_sel    = 1'b0;
        w_an_nxt    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_eff == IDX_W'(i)) begin
                w_nib       = w_digits_eff[4*i +: 4];
                w_blank_sel = w_blank[i];
                w_dp_sel    = i_dp[i];
                w_an_nxt[i] = 1'b1;
            end
        end
    end

    // Glyph priority: overflow dash, then leading-zero blank, then the font.
    always_comb begin
        if (w_ovf_eff) begin
            w_glyph = GLYPH_DASH;
        end else if (w_blank_sel) begin
            w_glyph = GLYPH_BLANK;
        end else begin
            w_glyph = font_lookup(w_nib);
        end
        w_seg_nxt = {w_dp_sel, w_glyph};
    end

    // Output register; polarity is applied only here, everything upstream is active-high.
    always_ff @(posedge i_clk) begin
        if (ACTIVE_LOW != 0) begin
            r_seg <= ~w_seg_nxt;
            r_an  <= ~w_an_nxt;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign o_seg      = r_seg;
    assign o_an       = r_an;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: a 4-digit and a 3-digit instance, active-high outputs.
// Latency: checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: loads issued while busy are expected to be dropped.
module tb_seg_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp4;
    logic        busy4;
    logic [7:0]  seg4;
    logic [3:0]  an4;
    logic        ovf4;

    logic        load3;
    logic [2:0]  dp3;
    logic        busy3;
    logic [7:0]  seg3;
    logic [2:0]  an3;
    logic        ovf3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_display_ctrl #(
        .NUM_DIGITS  (4),
        .VALUE_W     (14),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (0)
    ) dut4 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_value    (value),
        .i_load     (load),
        .o_busy     (busy4),
        .i_blank_lz (blank_lz),
        .i_dp       (dp4),
        .o_seg      (seg4),
        .o_an       (an4),
        .o_overflow (ovf4)
    );

    seg_display_ctrl #(
        .NUM_DIGITS  (3),
        .VALUE_W     (14),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (0)
    ) dut3 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_value    (value),
        .i_load     (load3),
        .o_busy     (busy3),
        .i_blank_lz (blank_lz),
        .i_dp       (dp3),
        .o_seg      (seg3),
        .o_an       (an3),
        .o_overflow (ovf3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until the 4-digit instance scans digit k, then check its glyph.
    task automatic chk_digit(input string tag, input int k, input logic [7:0] exp);
        logic [3:0] target;
        int n;
        target = 4'(1 << k);
        n = 0;
        while (an4 !== target && n < 24) begin
            @(negedge clk);
            n++;
        end
        if (an4 !== target) begin
            checks++;
            errors++;
            $error("FAIL %s: timeout waiting for an=%b, observed an=%b", tag, target, an4);
        end else begin
            chk(tag, {24'd0, seg4}, {24'd0, exp});
        end
    endtask

    task automatic start_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Returns on the first falling edge where busy is low.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy4 !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy4 !== 1'b0) begin
            checks++;
            errors++;
            $error("FAIL %s: timeout waiting for busy=0, observed busy=%b", tag, busy4);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp1234 [4];
        logic [3:0] prev_an;
        logic [2:0] prev3;
        logic [2:0] exp3;
        bit         found;
        int         n;

        exp1234 = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        rst      = 1'b1;
        value    = '0;
        load     = 1'b0;
        load3    = 1'b0;
        blank_lz = 1'b0;
        dp4      = 4'b0000;
        dp3      = 3'b010;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_an",   {28'd0, an4}, 32'h1);
        chk("rst_seg",  {24'd0, seg4}, 32'h3F);
        chk("rst_busy", {31'd0, busy4}, 32'h0);
        chk("rst_ovf",  {31'd0, ovf4}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1234: busy length, then scan order, period and glyphs
        start_load(14'd1234);
        n = 0;
        while (busy4 === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", n, 15);
        chk("ovf_1234", {31'd0, ovf4}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            prev_an = an4;
            @(negedge clk);
            if (an4 === 4'b0001 && prev_an !== 4'b0001) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL scan_start: no transition to an=0001, observed an=%b", an4);
        end
        for (int k = 0; k < 4; k++) begin
            chk("scan_an",  {28'd0, an4}, 32'(1 << k));
            chk("scan_seg", {24'd0, seg4}, {24'd0, exp1234[k]});
            repeat (4) @(negedge clk);
        end

        // 7 with leading-zero blanking on and off, then dp over blanked digits
        blank_lz = 1'b1;
        start_load(14'd7);
        wait_idle("idle_7");
        @(negedge clk);
        chk_digit("lz_d0", 0, 8'h07);
        chk_digit("lz_d1", 1, 8'h00);
        chk_digit("lz_d2", 2, 8'h00);
        chk_digit("lz_d3", 3, 8'h00);
        blank_lz = 1'b0;
        @(negedge clk);
        chk_digit("nolz_d1", 1, 8'h3F);
        chk_digit("nolz_d2", 2, 8'h3F);
        chk_digit("nolz_d3", 3, 8'h3F);
        chk_digit("nolz_d0", 0, 8'h07);
        blank_lz = 1'b1;
        dp4      = 4'b0101;
        @(negedge clk);
        chk_digit("dp_d0", 0, 8'h87);
        chk_digit("dp_d2", 2, 8'h80);
        chk_digit("dp_d1", 1, 8'h00);
        blank_lz = 1'b0;
        dp4      = 4'b0000;

        // 10000 overflows to dashes; dp still honoured
        start_load(14'd10000);
        wait_idle("idle_10000");
        @(negedge clk);
        chk("ovf_set", {31'd0, ovf4}, 32'h1);
        chk_digit("ovf_d0", 0, 8'h40);
        chk_digit("ovf_d1", 1, 8'h40);
        chk_digit("ovf_d2", 2, 8'h40);
        dp4 = 4'b1000;
        @(negedge clk);
        chk_digit("ovf_d3dp", 3, 8'hC0);
        dp4 = 4'b0000;
        @(negedge clk);

        // 9999 clears overflow; previous display holds during conversion
        start_load(14'd9999);
        chk("hold_busy", {31'd0, busy4}, 32'h1);
        chk("hold_ovf",  {31'd0, ovf4}, 32'h1);
        chk("hold_seg",  {24'd0, seg4}, 32'h40);
        wait_idle("idle_9999");
        @(negedge clk);
        chk("ovf_clr", {31'd0, ovf4}, 32'h0);
        chk_digit("nines_d0", 0, 8'h6F);
        chk_digit("nines_d1", 1, 8'h6F);
        chk_digit("nines_d2", 2, 8'h6F);
        chk_digit("nines_d3", 3, 8'h6F);

        // Load while busy is dropped and not queued
        start_load(14'd1111);
        repeat (2) @(negedge clk);
        value = 14'd2222;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_idle("idle_1111");
        repeat (3) @(negedge clk);
        chk("drop_busy", {31'd0, busy4}, 32'h0);
        chk_digit("drop_d0", 0, 8'h06);
        chk_digit("drop_d3", 3, 8'h06);

        // Load in the cycle busy falls is accepted
        start_load(14'd3456);
        wait_idle("idle_3456");
        value = 14'd5678;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("fall_accept", {31'd0, busy4}, 32'h1);
        wait_idle("idle_5678");
        @(negedge clk);
        chk_digit("b2b_d0", 0, 8'h7F);
        chk_digit("b2b_d1", 1, 8'h07);
        chk_digit("b2b_d2", 2, 8'h7D);
        chk_digit("b2b_d3", 3, 8'h6D);

        // Reset mid-conversion aborts and clears the display
        start_load(14'd4321);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy4}, 32'h0);
        chk("abort_an",   {28'd0, an4}, 32'h1);
        chk("abort_seg",  {24'd0, seg4}, 32'h3F);
        chk("abort_ovf",  {31'd0, ovf4}, 32'h0);
        repeat (20) @(negedge clk);
        chk("abort_idle", {31'd0, busy4}, 32'h0);
        chk_digit("abort_d3", 3, 8'h3F);
        chk_digit("abort_d0", 0, 8'h3F);

        // 3-digit instance: one-hot scan, 2->0 wrap, dp only on digit 1
        prev3 = an3;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("an3_onehot", {31'd0, (an3 === 3'b001 || an3 === 3'b010 || an3 === 3'b100)}, 32'h1);
            chk("an3_dp", {31'd0, seg3[7]}, {31'd0, (an3 === 3'b010)});
            chk("an3_glyph", {25'd0, seg3[6:0]}, 32'h3F);
            if (an3 !== prev3) begin
                exp3 = (prev3 === 3'b100) ? 3'b001 : (prev3 << 1);
                chk("an3_step", {29'd0, an3}, {29'd0, exp3});
            end
            prev3 = an3;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 Parameter VALUE_W, default 14, binary input width, legal range 4..27.
REQ-003 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot, minimum 2.
REQ-004 Parameter ACTIVE_LOW, default 1; 1 gives active-low seg and an, 0 gives active-high.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 value  input  VALUE_W  unsigned binary number to display.
REQ-008 load  input  1  request to convert and latch value.
REQ-009 busy  output  1  conversion in progress; load ignored while high.
REQ-010 blank_lz  input  1  enables leading-zero blanking, sampled live.
REQ-011 dp  input  NUM_DIGITS  per-digit decimal point enable, bit 0 = least significant digit, sampled live.
REQ-012 seg  output  8  bit 7 = dp, bits 6:0 = segments g..a, registered.
REQ-013 an  output  NUM_DIGITS  one-hot digit enable, bit 0 = least significant digit, registered.
REQ-014 overflow  output  1  latched value exceeds 10^NUM_DIGITS-1.

Function
REQ-015 Converter FSM states IDLE, SHIFT, COMMIT; IDLE -> SHIFT on load=1 with busy=0 (accept edge t), value captured at t.
REQ-016 SHIFT shall perform one double-dabble step (add-3 on BCD nibbles >=5, then shift left 1) per cycle, exactly VALUE_W cycles.
REQ-017 SHIFT -> COMMIT after the VALUE_W-th step; COMMIT writes digit registers and overflow, then -> IDLE.
REQ-018 busy shall be high from edge t through edge t+VALUE_W+1, i.e. VALUE_W+1 cycles; new digits visible from edge t+VALUE_W+1.
REQ-019 load while busy=1 shall be dropped, not queued; load in the cycle busy falls is accepted.
REQ-020 Displayed digits shall hold previous committed value during conversion (no partial results).
REQ-021 overflow=1 when captured value > 10^NUM_DIGITS-1; then every digit shows dash (segment g only), dp still honoured.
REQ-022 Refresh counter counts 0..REFRESH_DIV-1; on terminal count, digit index increments, wrapping from NUM_DIGITS-1 to 0 (non-power-of-2 wrap).
REQ-023 an/seg shall reflect the current index one cycle after the index changes; exactly one an bit active at all times after reset.
REQ-024 Font: standard 0-9 patterns (0 = a..f, 1 = b,c, ... 9 = a,b,c,d,f,g); non-decimal nibble shall drive all segments off.
REQ-025 Leading-zero blanking: with blank_lz=1, zero digits above the most significant nonzero digit show all segments off; digit 0 is never blanked; dp unaffected.
REQ-026 ACTIVE_LOW=1 inverts seg and an at the output register; logic internally active-high.
REQ-027 NUM_DIGITS=1 shall hold index at 0 permanently.

Reset
REQ-028 rst=1 at an edge shall clear refresh counter, digit index, digit registers and overflow to 0, FSM to IDLE, busy to 0.
REQ-029 After reset outputs show digit 0 active, glyph "0", dp per dp[0]; reset asserted mid-conversion aborts it and discards the captured value.

Structure
REQ-030 Shared package seg_pkg holds the font constants, dash and blank glyphs, and the converter state enum.
REQ-031 Converter shall be sub-module bin2bcd_seq (value, start, busy, done, bcd, overflow), parametrised by VALUE_W and NUM_DIGITS.

Verification (REFRESH_DIV=4, NUM_DIGITS=4, VALUE_W=14, ACTIVE_LOW=0)
REQ-032 Reset, load value=1234 -> busy high 15 cycles, then an cycles 0001,0010,0100,1000 every 4 cycles with seg 0x66,0x4F,0x5B,0x06.
REQ-033 value=7, blank_lz=1 -> digit 0 seg 0x07, digits 1-3 seg 0x00; blank_lz=0 -> digits 1-3 seg 0x3F.
REQ-034 value=10000 -> overflow=1, all digits seg 0x40; subsequent value=9999 -> overflow=0, all seg 0x6F.
REQ-035 Second load 3 cycles after first accept -> ignored; display shows first value only; load on busy-fall cycle accepted.
REQ-036 rst mid-conversion of 4321 -> busy=0 next cycle, display shows 0000 glyphs, an=0001.
REQ-037 NUM_DIGITS=3 build, dp=3'b010 -> index wraps 2->0, an never 0 or multi-hot, seg bit 7 set only when an=010.
